// File: rtl/fir_sample_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_feeder_if
// Description : Signal bundle between the FIR sample feeder and its
//               surroundings: upstream sample stream, FIR core sample/result
//               handshake, downstream result stream and status flags.
//               master modport : the feeder itself
//               slave modport  : sample source / FIR core / result sink
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_sample_feeder_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 38
);
  // upstream sample stream
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  // FIR core side
  logic [DATA_W-1:0] fir_input;
  logic              fir_input_valid;
  logic [OUT_W-1:0]  fir_output;
  logic              fir_output_valid;
  // downstream result stream
  logic [OUT_W-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  // status
  logic              busy;
  logic              timeout_err;

  modport master (
    input  s_data, s_valid, fir_output, fir_output_valid, m_ready,
    output s_ready, fir_input, fir_input_valid, m_data, m_valid, busy, timeout_err
  );

  modport slave (
    output s_data, s_valid, fir_output, fir_output_valid, m_ready,
    input  s_ready, fir_input, fir_input_valid, m_data, m_valid, busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_feeder
// Description : Initiator-side driver for the FIR sample interface. Buffers
//               upstream samples in a small FIFO, issues one sample at a time
//               to the FIR as a single-cycle valid pulse, waits for the FIR
//               result, and holds it on a downstream valid/ready stream until
//               accepted. At most one sample is in flight.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - fir_sample_feeder_if.master (s_* upstream, fir_*
//                       FIR core, m_* downstream, busy, timeout_err)
// Parameters  : DATA_W, OUT_W, FIFO_DEPTH (power of two >= 2), TIMEOUT
// Options     : FIR_FEEDER_WATCHDOG_EN - when defined, a WAIT lasting TIMEOUT
//               cycles without a FIR result drops the sample, pulses
//               timeout_err and returns to IDLE. When undefined, WAIT never
//               expires and timeout_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_feeder #(
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 38,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  fir_sample_feeder_if.master bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Reject configurations the pointer arithmetic cannot handle.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_cfg_error
    $error("fir_sample_feeder: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t            state_q;
  logic              rst_released_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [DATA_W-1:0] fir_input_q;
  logic              fir_input_valid_q;
  logic [OUT_W-1:0]  m_data_q;
  logic              m_valid_q;
  logic              busy_q;

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic s_ready;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Readiness depends only on the registered fill level, so a pop in the
  // same cycle never lets a full FIFO accept a sample.
  assign s_ready    = !fifo_full && rst_released_q;
  assign push       = bus.s_valid && s_ready;
  // The head is consumed on the edge that moves IDLE -> ISSUE.
  assign pop        = (state_q == IDLE) && !fifo_empty;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: the pointers and fill level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_released_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      rst_released_q <= 1'b1;
      count_q        <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Issue / wait / hold sequencer
  // --------------------------------------------------------------------------
`ifdef FIR_FEEDER_WATCHDOG_EN
  // Counts completed WAIT cycles; expiry happens on the edge that would make
  // it reach TIMEOUT, so a sample gets exactly TIMEOUT WAIT cycles.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] wait_cnt_q;
  logic          timeout_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      fir_input_q       <= '0;
      fir_input_valid_q <= 1'b0;
      m_data_q          <= '0;
      m_valid_q         <= 1'b0;
      busy_q            <= 1'b0;
`ifdef FIR_FEEDER_WATCHDOG_EN
      wait_cnt_q        <= '0;
      timeout_err_q     <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; they are raised for a single cycle below.
      fir_input_valid_q <= 1'b0;
`ifdef FIR_FEEDER_WATCHDOG_EN
      timeout_err_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            // Load the sample together with the valid pulse so that both
            // are presented to the FIR during the ISSUE cycle; fir_input
            // then holds through WAIT and HOLD.
            fir_input_q       <= mem_q[rd_ptr_q];
            fir_input_valid_q <= 1'b1;
            busy_q            <= 1'b1;
            state_q           <= ISSUE;
          end
        end

        ISSUE: begin
`ifdef FIR_FEEDER_WATCHDOG_EN
          wait_cnt_q <= '0;
`endif
          state_q <= WAIT;
        end

        WAIT: begin
          // A result arriving on the expiry cycle is captured, not dropped.
          if (bus.fir_output_valid) begin
            m_data_q  <= bus.fir_output;
            m_valid_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= HOLD;
          end
`ifdef FIR_FEEDER_WATCHDOG_EN
          else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
`endif
        end

        HOLD: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.s_ready         = s_ready;
  assign bus.fir_input       = fir_input_q;
  assign bus.fir_input_valid = fir_input_valid_q;
  assign bus.m_data          = m_data_q;
  assign bus.m_valid         = m_valid_q;
  assign bus.busy            = busy_q;
`ifdef FIR_FEEDER_WATCHDOG_EN
  assign bus.timeout_err     = timeout_err_q;
`else
  assign bus.timeout_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_sample_feeder
// Description : Self-checking bench for fir_sample_feeder. A queue of
//               accepted samples predicts the issue order; the bench plays
//               the FIR core and the downstream sink, so every expected
//               result is the value it handed to the FIR itself.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sample_feeder;

  localparam int DATA_W     = 16;
  localparam int OUT_W      = 38;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fir_sample_feeder_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  fir_sample_feeder #(
    .DATA_W     (DATA_W),
    .OUT_W      (OUT_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] model_q  [$];  // accepted, not yet issued
  logic [DATA_W-1:0] issued_q [$];  // seen on the FIR input, not yet checked
  logic [DATA_W-1:0] last_exp;
  int pulse_cnt = 0;
  int to_cnt    = 0;
  int cyc       = 0;
  int issue_cyc = 0;
  int to_cyc    = 0;

  // Observer of the FIR-side pulses, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n) begin
      if (bus.fir_input_valid) begin
        issued_q.push_back(bus.fir_input);
        pulse_cnt++;
        issue_cyc = cyc;
      end
      if (bus.timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed no event expected event within bound", tag);
  endtask

  function automatic logic [OUT_W-1:0] rnd_out();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[OUT_W-1:0];
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push(input logic [DATA_W-1:0] d);
    int n = 0;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      bound_fail("push_ready");
      return;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    model_q.push_back(d);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // Wait for the next issue and compare it with the oldest accepted sample.
  task automatic take_issue();
    int n = 0;
    while (issued_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (issued_q.size() == 0) begin
      bound_fail("issue_wait");
      return;
    end
    if (model_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL unexpected_issue: observed 0x%0h expected none", issued_q.pop_front());
      return;
    end
    last_exp = model_q.pop_front();
    chk("fir_input", issued_q.pop_front(), last_exp);
  endtask

  // Act as FIR (latency lat) and sink (stall cycles before accepting).
  task automatic serve(input int lat, input logic [OUT_W-1:0] res, input int stall);
    int pc;
    take_issue();
    pc = pulse_cnt;
    repeat (lat) @(negedge clk);
    chk("busy_wait", bus.busy, 1);
    chk("m_valid_wait", bus.m_valid, 0);
    bus.fir_output       = res;
    bus.fir_output_valid = 1'b1;
    @(negedge clk);
    bus.fir_output_valid = 1'b0;
    bus.fir_output       = rnd_out();
    chk("m_valid", bus.m_valid, 1);
    chk("m_data", bus.m_data, res);
    chk("busy_hold", bus.busy, 0);
    repeat (stall) @(negedge clk);
    // A stray result while holding must be ignored.
    bus.fir_output       = ~res;
    bus.fir_output_valid = 1'b1;
    @(negedge clk);
    bus.fir_output_valid = 1'b0;
    chk("m_data_hold", bus.m_data, res);
    chk("m_valid_hold", bus.m_valid, 1);
    chk("fir_input_stable", bus.fir_input, last_exp);
    chk("no_issue_in_flight", pulse_cnt, pc);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk("m_valid_clr", bus.m_valid, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] burst [5];
    int pc0;
    int to0;
    int k;
    burst[0] = 16'h0E11; burst[1] = 16'h089D; burst[2] = 16'hF960;
    burst[3] = 16'hF63A; burst[4] = 16'h0001;

    bus.s_valid          = 1'b0;
    bus.s_data           = '0;
    bus.fir_output       = '0;
    bus.fir_output_valid = 1'b0;
    bus.m_ready          = 1'b0;

    // ---- reset ----
    repeat (3) @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_fir_input", bus.fir_input, 0);
    chk("rst_fir_input_valid", bus.fir_input_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    rst_n = 1'b1;
    chk("s_ready_at_release", bus.s_ready, 0);
    @(negedge clk);
    @(negedge clk);
    chk("s_ready_after_release", bus.s_ready, 1);

    // ---- FIR result while idle is ignored ----
    bus.fir_output       = rnd_out();
    bus.fir_output_valid = 1'b1;
    @(negedge clk);
    bus.fir_output_valid = 1'b0;
    chk("idle_fov_m_valid", bus.m_valid, 0);
    chk("idle_fov_busy", bus.busy, 0);

    // ---- single sample, 2-cycle issue latency, 200-cycle FIR ----
    pc0 = pulse_cnt;
    push(16'h0125);
    chk("issue_not_early", bus.fir_input_valid, 0);
    @(negedge clk);
    chk("issue_latency", bus.fir_input_valid, 1);
    chk("issue_data", bus.fir_input, 16'h0125);
    serve(200, 38'h0000001234, 5);
    chk("single_pulse_count", pulse_cnt - pc0, 1);

    // ---- burst into a 4-deep FIFO ----
    for (int i = 0; i < 5; i++) push(burst[i]);
    chk("burst_full_s_ready", bus.s_ready, 0);
    serve(3, rnd_out(), 50);
    chk("fifo_retained", bus.s_ready, 0);
    for (int i = 1; i < 5; i++) serve($urandom_range(1, 30), rnd_out(), $urandom_range(0, 5));
    chk("burst_model_empty", model_q.size(), 0);

    // ---- randomized traffic ----
    for (int it = 0; it < 20; it++) begin
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) push(DATA_W'($urandom));
      for (int j = 0; j < k; j++) serve($urandom_range(1, 20), rnd_out(), $urandom_range(0, 4));
    end
    chk("random_model_empty", model_q.size(), 0);

    // ---- FIR never answers ----
    to0 = to_cnt;
    push(DATA_W'($urandom));
    take_issue();
`ifdef FIR_FEEDER_WATCHDOG_EN
    pc0 = issue_cyc;
    push(DATA_W'($urandom));
    repeat (TIMEOUT + 10) @(negedge clk);
    chk("wd_pulse_count", to_cnt - to0, 1);
    chk("wd_expiry_time", to_cyc - pc0, TIMEOUT + 1);
    chk("wd_no_m_valid", bus.m_valid, 0);
    take_issue();
`else
    repeat (TIMEOUT + 45) @(negedge clk);
    chk("nowd_busy", bus.busy, 1);
    chk("nowd_timeout_err", to_cnt - to0, 0);
    chk("nowd_m_valid", bus.m_valid, 0);
`endif

    // ---- reset while waiting with samples queued ----
    for (int i = 0; i < 3; i++) push(DATA_W'($urandom));
    chk("pre_reset_busy", bus.busy, 1);
    chk("pre_reset_queued", issued_q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_s_ready", bus.s_ready, 0);
    chk("midrst_fir_input", bus.fir_input, 0);
    model_q.delete();
    issued_q.delete();
    pc0 = pulse_cnt;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_no_issue", pulse_cnt, pc0);
    chk("post_reset_s_ready", bus.s_ready, 1);
    push(16'hBEEF);
    serve(7, rnd_out(), 2);
    chk("post_reset_pulse_count", pulse_cnt - pc0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Initiator-side driver for the FIR filter's sample interface: accepts 16-bit samples from an upstream valid/ready stream and buffers them in a small FIFO. Issues each sample to the FIR as a single-cycle input-valid pulse, then waits for the FIR's output-valid before issuing the next. Captures each 38-bit FIR result and presents it on a downstream valid/ready stream. Sits between the sample source and the FIR core in the filter top level.

## Interface
- DATA_W, 16, sample width (FIR input width)
- OUT_W, 38, FIR result width
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥2
- TIMEOUT, 255, max cycles to wait for FIR output_valid (used only with watchdog)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  DATA_W  upstream sample
- s_valid  in  1  upstream sample valid
- s_ready  out  1  feeder can accept a sample
- fir_input  out  DATA_W  sample to FIR
- fir_input_valid  out  1  one-cycle issue pulse to FIR
- fir_output  in  OUT_W  FIR result
- fir_output_valid  in  1  FIR result valid
- m_data  out  OUT_W  captured result
- m_valid  out  1  result valid downstream
- m_ready  in  1  downstream accepts result
- busy  out  1  sample in flight (ISSUE or WAIT)
- timeout_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- Push: s_valid && s_ready writes s_data to the FIFO tail.
- s_ready = !full && rst_released. rst_released is a register cleared by reset and set on the first clock edge after reset release.
- When the FIFO is full, s_ready stays low even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: FIFO non-empty → ISSUE.
  - ISSUE: fir_input_valid=1 for exactly this cycle; pop FIFO head into fir_input register; clear wait counter → WAIT.
  - WAIT: counter increments each cycle. fir_output_valid → capture fir_output into m_data, m_valid=1 → HOLD.
  - HOLD: hold m_data/m_valid until m_ready → IDLE.
- fir_input updates only in ISSUE; it holds stable through WAIT and HOLD, since the FIR samples it after the valid pulse.
- fir_output_valid seen in IDLE, ISSUE or HOLD is ignored; no capture and no state change.
- fir_output_valid in the same cycle as watchdog expiry: the capture wins, with no error.
- busy = state is ISSUE or WAIT.
- All arithmetic is widthless passthrough: no rounding or truncation of fir_output.

## Timing
- Reset values of outputs: s_ready=0, fir_input=0, fir_input_valid=0, m_data=0, m_valid=0, busy=0, timeout_err=0. FSM=IDLE, FIFO empty, counter=0.
- Issue latency: a sample accepted at edge N into an empty FIFO with FSM in IDLE gives fir_input_valid high in the cycle after edge N+1, i.e. 2 cycles.
- Result latency: fir_output_valid sampled high at edge K gives m_valid high from edge K, i.e. the next cycle.
- Back-to-back issue spacing is ≥ 3 cycles plus FIR latency plus downstream stall. At most one sample is in flight.
- Reset asserted mid-operation: everything returns to reset values immediately and asynchronously. FIFO contents and in-flight results are discarded.

## Configuration
- FIR_FEEDER_WATCHDOG_EN defined:
  - In WAIT, when the counter reaches TIMEOUT without fir_output_valid, pulse timeout_err for one cycle and go to IDLE.
  - The sample is dropped and m_valid is not raised.
- FIR_FEEDER_WATCHDOG_EN undefined:
  - WAIT persists indefinitely, timeout_err is tied 0 and the counter is not instantiated.

## Test plan
- Reset: hold rst_n=0 for 3 cycles and release → all outputs 0; s_ready=1 from the second edge after release.
- Single sample: push 0x0125; FIR model returns 0x0000001234 after 200 cycles → exactly one fir_input_valid pulse with fir_input=0x0125; m_data=0x0000001234 and m_valid=1 until m_ready.
- Burst: push 0x0E11, 0x089D, 0xF960, 0xF63A, 0x0001 back-to-back with FIFO_DEPTH=4 → s_ready drops after 4 are held. All 5 are issued in order, each only after the previous result is accepted.
- Downstream stall: m_ready=0 for 50 cycles after m_valid → m_data stable, no new fir_input_valid, FIFO retains the rest.
- Watchdog (macro defined, TIMEOUT=255): FIR never responds → timeout_err pulses once, 255 cycles after ISSUE. The next queued sample is then issued; without the macro, busy stays 1.
- Mid-flight reset: assert rst_n in WAIT with 3 samples queued → m_valid=0 and FIFO empty. No fir_input_valid occurs until new pushes arrive.
